// File: rtl/spi_slave_gen.sv
// SPI slave running on the system clock: SCK/SS/SDIN are oversampled through
// synchronisers; DW-bit words, any CPOL/CPHA, MSB/LSB first, back-to-back words.
module spi_slave_gen #(
  parameter int DW   = 8,
  parameter bit CPOL = 1'b1,
  parameter bit CPHA = 1'b1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          ss,
  input  logic          sck,
  input  logic          sdin,
  output logic          sdout,
  input  logic          ten,
  input  logic          mlb,
  input  logic [DW-1:0] tdata,
  input  logic          tvalid,
  output logic          tready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  input  logic          rready,
  output logic          done,
  output logic          ovr,
  output logic          udr,
  input  logic          clr
);
  localparam int CW = $clog2(DW);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ss_p0, r_ss_p1;
  logic          r_sck_p0, r_sck_p1, r_sck_p2;
  logic          r_sdin_p0, r_sdin_p1;
  logic [DW-1:0] r_treg, r_rreg, r_rdata;
  logic [CW-1:0] r_cnt;
  logic          r_first, r_sdo;
  logic          r_tready, r_rvalid, r_done, r_ovr, r_udr;

  logic          w_frame_start, w_abort, w_active;
  logic          w_sck_edge, w_lead, w_trail, w_sample, w_shift;
  logic          w_skip, w_boundary, w_load, w_complete;
  logic [DW-1:0] w_rnext, w_tshift;

  // Stage p0/p1: two-flop synchronisers; p2 on sck gives edge detection
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ss_p0   <= 1'b1;
      r_ss_p1   <= 1'b1;
      r_sck_p0  <= CPOL;
      r_sck_p1  <= CPOL;
      r_sck_p2  <= CPOL;
      r_sdin_p0 <= 1'b0;
      r_sdin_p1 <= 1'b0;
    end else begin
      r_ss_p0   <= ss;
      r_ss_p1   <= r_ss_p0;
      r_sck_p0  <= sck;
      r_sck_p1  <= r_sck_p0;
      r_sck_p2  <= r_sck_p1;
      r_sdin_p0 <= sdin;
      r_sdin_p1 <= r_sdin_p0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_ss_p1) begin
          w_state_nxt   = XFER;
          w_frame_start = 1'b1;
        end
      end
      XFER: begin
        if (r_ss_p1) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_active   = (r_state == XFER) && !r_ss_p1;
  assign w_sck_edge = r_sck_p1 ^ r_sck_p2;
  assign w_lead     = w_sck_edge && (r_sck_p1 != CPOL);
  assign w_trail    = w_sck_edge && (r_sck_p1 == CPOL);
  assign w_sample   = w_active && (CPHA ? w_trail : w_lead);
  assign w_shift    = w_active && (CPHA ? w_lead : w_trail);

  // A shift edge seen with the counter at zero starts a new word; for CPHA=1
  // the very first one belongs to the word already loaded at SS fall.
  assign w_skip     = CPHA && r_first;
  assign w_boundary = w_shift && (r_cnt == '0) && !w_skip;
  assign w_load     = w_frame_start || w_boundary;
  assign w_complete = w_sample && (r_cnt == CW'(DW - 1));

  assign w_rnext  = mlb ? {r_rreg[DW-2:0], r_sdin_p1} : {r_sdin_p1, r_rreg[DW-1:1]};
  assign w_tshift = mlb ? {r_treg[DW-2:0], 1'b1}      : {1'b1, r_treg[DW-1:1]};

  // Stage: word datapath, counter, handshakes and sticky flags
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_treg   <= '1;
      r_rreg   <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_sdo    <= 1'b1;
      r_tready <= 1'b0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_udr    <= 1'b0;
    end else begin
      r_tready <= w_load && tvalid;
      r_done   <= w_complete;
      r_sdo    <= mlb ? r_treg[DW-1] : r_treg[0];

      if (w_load)                  r_treg <= tvalid ? tdata : '1;
      else if (w_shift && !w_skip) r_treg <= w_tshift;

      if (w_frame_start)           r_first <= 1'b1;
      else if (w_shift)            r_first <= 1'b0;

      if (w_frame_start || w_abort) r_cnt <= '0;
      else if (w_sample)            r_cnt <= w_complete ? '0 : r_cnt + CW'(1);

      if (w_sample)   r_rreg  <= w_rnext;
      if (w_complete) r_rdata <= w_rnext;

      if (w_complete)              r_rvalid <= 1'b1;
      else if (r_rvalid && rready) r_rvalid <= 1'b0;

      if (w_complete && r_rvalid && !rready) r_ovr <= 1'b1;
      else if (clr)                          r_ovr <= 1'b0;

      if (w_load && !tvalid) r_udr <= 1'b1;
      else if (clr)          r_udr <= 1'b0;
    end
  end

  assign sdout  = (!ss && ten) ? r_sdo : 1'bz;
  assign tready = r_tready;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign done   = r_done;
  assign ovr    = r_ovr;
  assign udr    = r_udr;

endmodule
